// File: rtl/mul_pkg.sv
// Shared constants and state type for the shift-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_WIDTH      = 32;
    localparam int unsigned MUL_COUNT_W    = 6;
    localparam int unsigned MUL_LAST_COUNT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_32_shift_add_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carries.
module CLA_32
    import mul_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    input  logic                 c_in,
    output logic [MUL_WIDTH-1:0] sum,
    output logic                 c_out,
    output logic                 overflow
);

    logic [MUL_WIDTH-1:0] g;
    logic [MUL_WIDTH-1:0] p;
    logic [MUL_WIDTH-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic carry;
        logic gg;
        logic gp;
        c     = '0;
        carry = c_in;
        for (int unsigned k = 0; k < MUL_WIDTH / 4; k++) begin
            gp = &p[4*k +: 4];
            gg = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            c[4*k]   = carry;
            c[4*k+1] = g[4*k] | (p[4*k] & carry);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
            // group carry skips the four bit positions of this group
            carry = gg | (gp & carry);
        end
        c_out = carry;
    end

    assign sum      = p ^ c;
    assign overflow = c[MUL_WIDTH-1] ^ c_out;

endmodule

// File: rtl/mul_32_shift_add.sv
// Sequential unsigned 32x32->64 shift-add multiplier around one CLA_32.
// Optional MUL_ZERO_BYPASS_EN: zero operand goes straight to DONE.
module mul_32_shift_add
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [MUL_COUNT_W-1:0] LAST_CNT = MUL_COUNT_W'(MUL_LAST_COUNT);

    mul_state_t             state_q, state_d;
    logic [MUL_COUNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       mq_q, mq_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             adder_ovf_unused;

    assign addend = mq_q[0] ? mcand_q : '0;

    CLA_32 u_cla (
        .a        (hi_q),
        .b        (addend),
        .c_in     (1'b0),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (adder_ovf_unused)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        mq_d    = mq_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = a;
                    mq_d    = b;
                    hi_d    = '0;
                    count_d = '0;
                    state_d = RUN;
`ifdef MUL_ZERO_BYPASS_EN
                    if (a == '0 || b == '0) begin
                        mq_d    = '0;
                        state_d = DONE;
                    end
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // carry-out becomes the new top bit; sum LSB shifts into mq
                hi_d    = {c_out, sum[WIDTH-1:1]};
                mq_d    = {sum[0], mq_q[WIDTH-1:1]};
                count_d = count_q + MUL_COUNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            mq_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            mq_q    <= mq_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = {hi_q, mq_q};

endmodule
